// File: rtl/operand_loader.sv
// operand_loader: assembles a serial word stream into operand pairs and replays them to the register file
module operand_loader #(
  parameter int DATA = 256,
  parameter int WORD = 64,
  parameter int NUM_OPS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] in_data,
  output logic            wr_reg,
  output logic [DATA-1:0] Input_Data_A,
  output logic [DATA-1:0] Input_Data_B,
  output logic            busy,
  output logic            load_done
);
  localparam int WPO = DATA / WORD;
  localparam int WW = WPO > 1 ? $clog2(WPO) : 1;
  localparam int PW = NUM_OPS > 1 ? $clog2(NUM_OPS) : 1;
  typedef enum logic [1:0] {COLLECT, KICK, SEND, DONE} state_t;
  state_t state, state_n;
  logic [WW-1:0] w, w_n;
  logic h, h_n;
  logic [PW-1:0] p, p_n;
  logic [WPO-1:0][WORD-1:0] mem_a [NUM_OPS];
  logic [WPO-1:0][WORD-1:0] mem_b [NUM_OPS];
  logic hs, last_w, last_p;
  assign in_ready = state == COLLECT;
  assign hs = in_valid && in_ready;
  assign last_w = w == WW'(WPO - 1);
  assign last_p = p == PW'(NUM_OPS - 1);
  // Next state; the pair counter doubles as the replay index in SEND
  always_comb begin
    state_n = state;
    w_n = w;
    h_n = h;
    p_n = p;
    case (state)
      COLLECT: if (hs) begin
        w_n = last_w ? '0 : w + 1'b1;
        h_n = h ^ last_w;
        p_n = last_w && h ? (last_p ? '0 : p + 1'b1) : p;
        state_n = last_w && h && last_p ? KICK : COLLECT;
      end
      KICK: state_n = SEND;
      SEND: begin
        p_n = last_p ? '0 : p + 1'b1;
        state_n = last_p ? DONE : SEND;
      end
      default: state_n = COLLECT;
    endcase
  end
  // State, counters and outputs registered from the next-state decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      w <= '0;
      h <= 1'b0;
      p <= '0;
      wr_reg <= 1'b0;
      Input_Data_A <= '0;
      Input_Data_B <= '0;
      busy <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state <= state_n;
      w <= w_n;
      h <= h_n;
      p <= p_n;
      wr_reg <= state_n == KICK;
      Input_Data_A <= state_n == SEND ? mem_a[p_n] : '0;
      Input_Data_B <= state_n == SEND ? mem_b[p_n] : '0;
      busy <= state_n != COLLECT || w_n != '0 || h_n || p_n != '0;
      load_done <= state_n == DONE;
    end
  end
  // Operand storage is never cleared; every word is rewritten before replay
  always_ff @(posedge clk) begin
    if (hs) begin
      if (h) mem_b[p][w] <= in_data;
      else mem_a[p][w] <= in_data;
    end
  end
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: vector, directed and randomized checks of operand_loader against a burst-level model
module tb_operand_loader;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic in_ready, wr_reg, busy, load_done;
  logic [63:0] in_data = '0;
  logic [255:0] Input_Data_A, Input_Data_B;
  int errors = 0, checks = 0, cyc = 0, wr_cyc = 0, w1 = 0;
  logic [63:0] words [24];
  logic [255:0] obs_a [3];
  logic [255:0] obs_b [3];
  logic [255:0] v;
  typedef struct {int pair; int is_b; int word; logic [63:0] exp;} vec_t;
  vec_t tbl [6];

  operand_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_reg(wr_reg), .Input_Data_A(Input_Data_A), .Input_Data_B(Input_Data_B),
    .busy(busy), .load_done(load_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: pair k operand hb is the 4 stream words at k*8+hb*4, least significant first
  function automatic logic [255:0] opnd(input int k, input int hb);
    logic [255:0] r;
    for (int x = 0; x < 4; x++) r[x*64 +: 64] = words[k*8 + hb*4 + x];
    return r;
  endfunction

  task automatic rnd_words();
    for (int i = 0; i < 24; i++) words[i] = {$urandom, $urandom};
  endtask

  // stall: 0 none, 1 every third cycle, 2 random; junk drives DEAD words after collection; abort_k resets in that SEND cycle
  task automatic burst(input int stall, input bit junk, input int abort_k);
    int i, c;
    logic hs;
    i = 0;
    c = 0;
    while (i < 24 && c < 400) begin
      chk1("collect_ready", in_ready, 1'b1);
      chk1("collect_wr", wr_reg, 1'b0);
      chk1("collect_done", load_done, 1'b0);
      chk1("collect_busy", busy, i > 0);
      in_valid = !((stall == 1 && c % 3 == 2) || (stall == 2 && $urandom_range(0, 2) == 0));
      in_data = words[i];
      hs = in_valid && in_ready;
      tick();
      if (hs) i++;
      c++;
    end
    in_valid = 1'b0;
    if (i < 24) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: accepted %0d beats, required 24", i);
      return;
    end
    wr_cyc = cyc;
    chk1("kick_wr", wr_reg, 1'b1);
    chk1("kick_ready", in_ready, 1'b0);
    chk1("kick_busy", busy, 1'b1);
    chk1("kick_done", load_done, 1'b0);
    chk("kick_a", Input_Data_A, '0);
    chk("kick_b", Input_Data_B, '0);
    in_valid = junk;
    in_data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    for (int k = 0; k < 3; k++) begin
      obs_a[k] = Input_Data_A;
      obs_b[k] = Input_Data_B;
      chk($sformatf("send_a%0d", k), Input_Data_A, opnd(k, 0));
      chk($sformatf("send_b%0d", k), Input_Data_B, opnd(k, 1));
      chk1("send_wr", wr_reg, 1'b0);
      chk1("send_ready", in_ready, 1'b0);
      chk1("send_done", load_done, 1'b0);
      chk1("send_busy", busy, 1'b1);
      if (k == abort_k) begin
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_a", Input_Data_A, '0);
        chk("abort_b", Input_Data_B, '0);
        chk1("abort_wr", wr_reg, 1'b0);
        chk1("abort_done", load_done, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_ready", in_ready, 1'b1);
        repeat (6) begin
          tick();
          chk1("abort_no_done", load_done, 1'b0);
          chk1("abort_no_wr", wr_reg, 1'b0);
        end
        return;
      end
      tick();
    end
    chk1("done_pulse", load_done, 1'b1);
    chk1("done_ready", in_ready, 1'b0);
    chk1("done_busy", busy, 1'b1);
    chk1("done_wr", wr_reg, 1'b0);
    chk("done_a", Input_Data_A, '0);
    chk("done_b", Input_Data_B, '0);
    tick();
    in_valid = 1'b0;
    chk1("post_done", load_done, 1'b0);
    chk1("post_busy", busy, 1'b0);
    chk1("post_ready", in_ready, 1'b1);
    chk1("post_wr", wr_reg, 1'b0);
  endtask

  initial begin
    tbl = '{'{0, 0, 0, 64'h000}, '{0, 0, 1, 64'h001}, '{1, 1, 2, 64'h112},
            '{2, 1, 3, 64'h213}, '{1, 0, 3, 64'h103}, '{2, 0, 0, 64'h200}};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("rst_ready", in_ready, 1'b1);
    chk1("rst_wr", wr_reg, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", load_done, 1'b0);
    chk("rst_a", Input_Data_A, '0);
    chk("rst_b", Input_Data_B, '0);
    // basic load with the pair/operand/word tagged pattern
    for (int i = 0; i < 24; i++) words[i] = 64'((i / 8) * 256 + ((i % 8) / 4) * 16 + i % 4);
    burst(0, 1'b0, -1);
    for (int t = 0; t < 6; t++) begin
      v = tbl[t].is_b != 0 ? obs_b[tbl[t].pair] : obs_a[tbl[t].pair];
      chk($sformatf("table_p%0d_%s_w%0d", tbl[t].pair, tbl[t].is_b != 0 ? "b" : "a", tbl[t].word),
          {192'b0, v[tbl[t].word*64 +: 64]}, {192'b0, tbl[t].exp});
    end
    // same words with every third cycle stalled
    burst(1, 1'b0, -1);
    // junk driven during KICK/SEND/DONE, then fresh burst
    burst(0, 1'b1, -1);
    rnd_words();
    burst(0, 1'b0, -1);
    chk("after_junk_w0", {192'b0, obs_a[0][63:0]}, {192'b0, words[0]});
    // reset mid-collect after 10 beats
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = {32'hBAD0_0000, 32'(i)};
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("midrst_ready", in_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_wr", wr_reg, 1'b0);
    rnd_words();
    burst(0, 1'b0, -1);
    // reset during SEND k=1, then recovery with random gaps
    rnd_words();
    burst(0, 1'b0, 1);
    rnd_words();
    burst(2, 1'b0, -1);
    // back-to-back bursts
    rnd_words();
    burst(0, 1'b0, -1);
    w1 = wr_cyc;
    rnd_words();
    burst(0, 1'b0, -1);
    chk("b2b_period", 256'(wr_cyc - w1), 256'd29);
    // randomized bursts
    repeat (4) begin
      rnd_words();
      burst(2, $urandom_range(0, 1) == 1, -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream stage of the multiplier operand register file.
- Accepts operand pairs (A, B) as a serial stream of narrow bus words and assembles them into NUM_OPS full-width pairs in local storage.
- Once all pairs are captured, it issues a one-cycle write strobe, then presents pair 0, pair 1, … on consecutive cycles. This matches the register file's sequential slot-0/1/2 load.
- Signals completion back to the controlling sequencer.

Parameters:
- DATA, 256, operand width in bits (matches register-file width).
- WORD, 64, input bus word width; DATA must be an integer multiple of WORD.
- NUM_OPS, 3, number of operand pairs per load burst.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data carries a valid word this cycle.
- in_ready  out  1  loader accepts a word this cycle; transfer occurs when in_valid && in_ready.
- in_data  in  WORD  operand word.
- wr_reg  out  1  one-cycle strobe to the register file marking the start of a burst.
- Input_Data_A  out  DATA  operand A of the pair being transferred.
- Input_Data_B  out  DATA  operand B of the pair being transferred.
- busy  out  1  high from the first accepted word until load_done.
- load_done  out  1  one-cycle pulse in the cycle after the last pair is presented.

Behaviour:
- **Reset values:** in_ready=1, wr_reg=0, Input_Data_A=0, Input_Data_B=0, busy=0, load_done=0. Word/pair counters cleared; FSM goes to COLLECT.

- **Stream order:**
  - Per pair: DATA/WORD words of A, then DATA/WORD words of B. With the defaults this is 4+4 words.
  - Within each operand, words arrive least-significant first: word k fills bits [k*WORD +: WORD].
  - Pairs arrive in index order 0..NUM_OPS-1.
  - Total beats per burst = 2*NUM_OPS*DATA/WORD (24 with defaults).

- **FSM states:** COLLECT, KICK, SEND, DONE.

- **COLLECT:**
  - in_ready=1.
  - Each handshake writes in_data into the addressed word of local storage and advances the word counter.
  - Gaps on in_valid stall the counter; nothing is lost.
  - busy rises on the first accepted word.
  - The handshake on the final beat moves the FSM to KICK.

- **KICK (1 cycle):**
  - wr_reg=1, in_ready=0.
  - Input_Data_A/B=0.
  - Next state is SEND with pair index 0.

- **SEND (NUM_OPS cycles):**
  - In SEND cycle k, Input_Data_A/B = stored pair k, wr_reg=0, in_ready=0.
  - Pair k is therefore valid exactly k+1 cycles after the wr_reg cycle.
  - After k=NUM_OPS-1, go to DONE.

- **DONE (1 cycle):**
  - load_done=1, Input_Data_A/B=0, in_ready=0.
  - busy drops in the cycle after DONE.
  - Next state is COLLECT with counters cleared.

- **Output registration:** all outputs are registered; no combinational path from in_valid/in_data to any output except in_ready, which is a decode of the registered state.

- **Flow control outside COLLECT:** in_valid while in_ready=0 is ignored; in_data is not captured and no error is flagged.

- **Storage reuse:** local storage is not cleared between bursts. Every location is overwritten during COLLECT before it can be presented.

- **Reset mid-operation:**
  - Reset in any state aborts the burst.
  - Partially collected words are discarded: the counter returns to 0, and the next burst needs the full 24 beats.
  - No wr_reg or load_done is emitted for an aborted burst.

- **Back-to-back bursts:** the earliest next accepted word is the cycle after DONE. Minimum burst period = 24 + 1 + NUM_OPS + 1 cycles.

Test Plan:
1. **Basic load:** rst 2 cycles; 24 contiguous beats where in_data = 64'h(pair)(A/B)(word), e.g. pair1 B word2 = 64'h0000_0000_0000_0112.
   - wr_reg high exactly 1 cycle, one cycle after the 24th handshake.
   - Next three cycles present pairs 0,1,2 with A0[127:64]=64'h...0001, B2[255:192]=64'h...0213.
   - load_done one cycle after pair 2.
2. **Stalled input:** the same 24 words with in_valid deasserted on every third cycle -> identical outputs to test 1, shifted only in time; no word dropped or duplicated.
3. **Ignored input during burst:** drive in_valid=1 with 64'hDEAD... during KICK/SEND/DONE -> in_ready=0 throughout; next burst's pair 0 word 0 equals the first word sent after DONE, not DEAD.
4. **Reset mid-collect:** 10 beats, rst 1 cycle, then 24 fresh beats -> a single wr_reg and outputs reflect only the fresh data; no strobe after the first 14 of the fresh beats.
5. **Reset during SEND:** assert rst during SEND k=1 -> the next cycle shows Input_Data_A/B=0, wr_reg=0, load_done never pulses, busy=0, in_ready=1.
6. **Back-to-back bursts:** two bursts with distinct data and in_valid held high -> second burst's first handshake is the cycle after the first load_done; two wr_reg pulses 29 cycles apart; each burst's three pairs are correct.
